hkspi_master: RTL and testbench

HKSPI_MASTER -- requirements
Module: hkspi_master

---
 rtl/hkspi_pkg.sv | 27 ++
 rtl/hkspi_shifter.sv | 69 ++++++
 rtl/hkspi_master.sv | 146 ++++++++++++++
 tb/tb_hkspi_master.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hkspi_pkg.sv
// Shared definitions for the housekeeping SPI master: op encodings, FSM states, divider limits.
package hkspi_pkg;

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_RW    = 2'b11;

  localparam int unsigned DIV_MIN = 2;
  localparam int unsigned DIV_MAX = 255;
  localparam int unsigned DIV_W   = 8;
  localparam int unsigned GCNT_W  = 10;
  localparam int unsigned LEN_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    GUARD
  } state_t;

  // Streaming-mode command byte: op in the top two bits, remaining bits zero.
  function automatic logic [7:0] cmd_byte(input logic [1:0] op);
    return {op, 6'b000000};
  endfunction

endpackage

// File: rtl/hkspi_shifter.sv
// One-byte SPI mode-0 engine: generates SCK, shifts MSB first on SDI and samples SDO on rising SCK.
module hkspi_shifter
  import hkspi_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       sdo,
  output logic       sck,
  output logic       sdi,
  output logic       active,
  output logic       rx_done,
  output logic [7:0] rx,
  output logic       byte_end_c
);

  logic [7:0]       tx;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic             half_c;

  assign half_c     = active && (div_cnt == DIV_W'(DIV - 1));
  assign byte_end_c = half_c && sck && (bit_cnt == 3'd7);
  assign sdi        = tx[7];

  // A load restarts the low half-period, so back-to-back bytes keep uniform SCK timing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx      <= '0;
      rx      <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
      active  <= 1'b0;
      rx_done <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (load) begin
        tx      <= din;
        active  <= 1'b1;
        sck     <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (half_c) begin
        div_cnt <= '0;
        if (!sck) begin
          sck     <= 1'b1;
          rx      <= {rx[6:0], sdo};
          rx_done <= (bit_cnt == 3'd7);
        end else begin
          sck <= 1'b0;
          if (bit_cnt == 3'd7) begin
            active <= 1'b0;
            tx     <= '0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            tx      <= {tx[6:0], 1'b0};
          end
        end
      end else if (active) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/hkspi_master.sv
// Housekeeping SPI master: CMD, ADDR and streamed data bytes under one CSB frame.
// Define HKSPI_MASTER_RW_EN to enable the full-duplex op 2'b11 (otherwise it is rejected).
module hkspi_master
  import hkspi_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [3:0] cmd_len,
  input  logic [7:0] wdata,
  input  logic       wdata_valid,
  output logic       wdata_ready,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       busy,
  output logic       CSB,
  output logic       SCK,
  output logic       SDI,
  input  logic       SDO
);

  localparam int unsigned DIV_C = (DIV < DIV_MIN) ? DIV_MIN : ((DIV > DIV_MAX) ? DIV_MAX : DIV);

`ifdef HKSPI_MASTER_RW_EN
  localparam logic RW_EN = 1'b1;
`else
  localparam logic RW_EN = 1'b0;
`endif

  state_t            state;
  logic [1:0]        op_q;
  logic [7:0]        addr_q;
  logic [LEN_W-1:0]  remain;
  logic [GCNT_W-1:0] gcnt;

  logic       accept_c, op_ok_c, next_c, more_c, feed_c, load_c;
  logic [7:0] din_c;
  logic       active, rx_done, byte_end_c;
  logic [7:0] rx;

  // op_q[1] marks a byte stream going out from wdata, op_q[0] a byte stream coming back on rdata.
  assign accept_c = cmd_valid && cmd_ready;
  assign op_ok_c  = (cmd_op == OP_WRITE) || (cmd_op == OP_READ) || (RW_EN && (cmd_op == OP_RW));
  assign next_c   = ((state == ADDR) && byte_end_c) || ((state == DATA) && (byte_end_c || !active));
  assign more_c   = (state == ADDR) || (remain != '0);
  assign feed_c   = next_c && more_c && (!op_q[1] || wdata_valid);

  always_comb begin
    load_c = 1'b0;
    din_c  = 8'h00;
    if (accept_c && op_ok_c) begin
      load_c = 1'b1;
      din_c  = cmd_byte(cmd_op);
    end else if ((state == CMD) && byte_end_c) begin
      load_c = 1'b1;
      din_c  = addr_q;
    end else if (feed_c) begin
      load_c = 1'b1;
      din_c  = op_q[1] ? wdata : 8'h00;
    end
  end

  hkspi_shifter #(.DIV(DIV_C)) u_shifter (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load_c),
    .din        (din_c),
    .sdo        (SDO),
    .sck        (SCK),
    .sdi        (SDI),
    .active     (active),
    .rx_done    (rx_done),
    .rx         (rx),
    .byte_end_c (byte_end_c)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      remain      <= '0;
      gcnt        <= '0;
      CSB         <= 1'b1;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
    end else begin
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      if (rx_done && op_q[0] && (state == DATA)) begin
        rdata       <= rx;
        rdata_valid <= 1'b1;
      end
      if (feed_c) begin
        wdata_ready <= op_q[1];
        remain      <= remain - LEN_W'(1);
      end
      case (state)
        IDLE: begin
          if (accept_c) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (op_ok_c) begin
              state  <= CMD;
              CSB    <= 1'b0;
              op_q   <= cmd_op;
              addr_q <= cmd_addr;
              remain <= (cmd_len == 4'd0) ? LEN_W'(16) : LEN_W'(cmd_len);
            end
          end else begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        CMD:  if (byte_end_c) state <= ADDR;
        ADDR: if (byte_end_c) state <= DATA;
        DATA: begin
          if (byte_end_c && (remain == '0)) begin
            state <= GUARD;
            gcnt  <= '0;
          end
        end
        GUARD: begin
          // CSB rises one half-period after the last SCK fall, then 2*DIV clks of guard.
          gcnt <= gcnt + GCNT_W'(1);
          if (gcnt == GCNT_W'(DIV_C - 1)) CSB <= 1'b1;
          if (gcnt == GCNT_W'(3 * DIV_C - 1)) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hkspi_master.sv
// Directed bench for hkspi_master: instances with DIV 4 (main), 2 and 7 (timing only).
`timescale 1ns/1ps
module tb_hkspi_master;
  import hkspi_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [2:0] cmd_valid = '0;
  logic [2:0] cmd_ready, wdata_ready, rdata_valid, busy, csb, sck, sdi;
  logic [7:0] rdata [3];
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_addr = 8'h00;
  logic [3:0] cmd_len = 4'd0;
  logic [7:0] wdata = 8'h00;
  logic       wdata_valid = 1'b0;
  logic       sdo = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hkspi_master #(.DIV(g == 0 ? 4 : (g == 1 ? 2 : 7))) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .cmd_valid   (cmd_valid[g]),
      .cmd_ready   (cmd_ready[g]),
      .cmd_op      (cmd_op),
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .wdata       (wdata),
      .wdata_valid (wdata_valid),
      .wdata_ready (wdata_ready[g]),
      .rdata       (rdata[g]),
      .rdata_valid (rdata_valid[g]),
      .busy        (busy[g]),
      .CSB         (csb[g]),
      .SCK         (sck[g]),
      .SDI         (sdi[g]),
      .SDO         (sdo)
    );
  end

  // Pin monitors for the main instance.
  logic [63:0] bits;
  int          rises, edges, csb_bad, rd_n, wr_n;
  logic [7:0]  rd_q [4];

  always @(posedge sck[0]) begin
    bits = {bits[62:0], sdi[0]};
    rises++;
    if (csb[0] !== 1'b0) csb_bad++;
  end

  always @(sck[0]) edges++;

  always @(negedge clk) begin
    if (rdata_valid[0] === 1'b1) begin
      if (rd_n < 4) rd_q[rd_n] = rdata[0];
      rd_n++;
    end
    if (wdata_ready[0] === 1'b1) wr_n++;
  end

  // Chip model: after CMD and ADDR (16 falls), present resp MSB first on each falling SCK.
  logic [15:0] resp = 16'h0000;
  int          falls;
  always @(negedge sck[0] or posedge csb[0]) begin
    if (csb[0]) begin
      falls = 0;
      sdo   = 1'b0;
    end else begin
      falls++;
      if (falls >= 16 && falls < 32) sdo = resp[4'(31 - falls)];
    end
  end

  task automatic clear_mon;
    bits = '0; rises = 0; edges = 0; csb_bad = 0; rd_n = 0; wr_n = 0;
    rd_q[0] = '0; rd_q[1] = '0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [3:0] len);
    cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_valid[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (cmd_ready[0] !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready[0] !== 1'b1) begin
      errors++; $display("FAIL %s_done: cmd_ready got %b want 1", tag, cmd_ready[0]);
    end
  endtask

  task automatic wait_wready(input string tag);
    int n = 0;
    while (wdata_ready[0] !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (wdata_ready[0] !== 1'b1) begin
      errors++; $display("FAIL %s: wdata_ready got %b want 1", tag, wdata_ready[0]);
    end
  endtask

  task automatic test_reset;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({csb[0], sck[0], sdi[0], cmd_ready[0], wdata_ready[0], rdata_valid[0], busy[0]} !== 7'b1000000) begin
      errors++; $display("FAIL reset_pins: got %b want 1000000",
        {csb[0], sck[0], sdi[0], cmd_ready[0], wdata_ready[0], rdata_valid[0], busy[0]});
    end
    checks++;
    if (rdata[0] !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata[0]); end
    resetn = 1'b1;
    #1;
    checks++;
    if (cmd_ready[0] !== 1'b0) begin errors++; $display("FAIL release_ready0: got %b want 0", cmd_ready[0]); end
    @(negedge clk);
    checks++;
    if (cmd_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL release_ready1: ready/busy got %b%b want 10", cmd_ready[0], busy[0]);
    end
  endtask

  task automatic test_write;
    clear_mon();
    wdata = 8'hA5; wdata_valid = 1'b1;
    issue(OP_WRITE, 8'h08, 4'd1);
    checks++;
    if (busy[0] !== 1'b1 || csb[0] !== 1'b0) begin
      errors++; $display("FAIL write_start: busy/CSB got %b%b want 10", busy[0], csb[0]);
    end
    // A second request while busy must be ignored.
    cmd_op = OP_READ; cmd_valid[0] = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (cmd_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL write_busy: ready/busy got %b%b want 01", cmd_ready[0], busy[0]);
    end
    cmd_valid[0] = 1'b0;
    wait_idle("write");
    wdata_valid = 1'b0;
    checks++;
    if (rises !== 24) begin errors++; $display("FAIL write_rises: got %0d want 24", rises); end
    checks++;
    if (bits[23:0] !== 24'h8008A5) begin errors++; $display("FAIL write_bits: got %h want 8008a5", bits[23:0]); end
    checks++;
    if (csb_bad !== 0) begin errors++; $display("FAIL write_csb: high at %0d rises want 0", csb_bad); end
    checks++;
    if (wr_n !== 1 || csb[0] !== 1'b1) begin
      errors++; $display("FAIL write_wready: pulses %0d CSB %b want 1 1", wr_n, csb[0]);
    end
  endtask

  task automatic test_read;
    clear_mon();
    resp = 16'h1234;
    issue(OP_READ, 8'h01, 4'd2);
    wait_idle("read");
    checks++;
    if (rd_n !== 2) begin errors++; $display("FAIL read_count: got %0d want 2", rd_n); end
    checks++;
    if (rd_q[0] !== 8'h12 || rd_q[1] !== 8'h34) begin
      errors++; $display("FAIL read_data: got %h %h want 12 34", rd_q[0], rd_q[1]);
    end
    checks++;
    if (bits[31:0] !== 32'h40010000 || rises !== 32) begin
      errors++; $display("FAIL read_sdi: bits %h rises %0d want 40010000 32", bits[31:0], rises);
    end
    checks++;
    if (rdata[0] !== 8'h34) begin errors++; $display("FAIL read_hold: got %h want 34", rdata[0]); end
  endtask

  task automatic test_stall;
    int n = 0;
    int bad = 0;
    clear_mon();
    wdata = 8'h11; wdata_valid = 1'b1;
    issue(OP_WRITE, 8'h10, 4'd3);
    wait_wready("stall_b1");
    wdata_valid = 1'b0; wdata = 8'h22;
    while (!(rises >= 24 && sck[0] === 1'b0) && n < 2000) begin @(negedge clk); n++; end
    repeat (50) begin
      @(negedge clk);
      if (sck[0] !== 1'b0 || csb[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || rises !== 24) begin
      errors++; $display("FAIL stall_hold: bad %0d rises %0d want 0 24", bad, rises);
    end
    wdata_valid = 1'b1;
    wait_wready("stall_b2");
    wdata = 8'h33;
    @(negedge clk);
    wait_wready("stall_b3");
    wdata_valid = 1'b0;
    wait_idle("stall");
    checks++;
    if (bits[39:0] !== 40'h8010112233 || rises !== 40) begin
      errors++; $display("FAIL stall_bits: bits %h rises %0d want 8010112233 40", bits[39:0], rises);
    end
    checks++;
    if (wr_n !== 3 || csb_bad !== 0) begin
      errors++; $display("FAIL stall_wready: pulses %0d csb_bad %0d want 3 0", wr_n, csb_bad);
    end
  endtask

  task automatic test_reject;
    clear_mon();
    issue(2'b00, 8'h33, 4'd1);
    checks++;
    if (cmd_ready[0] !== 1'b0 || busy[0] !== 1'b1 || csb[0] !== 1'b1) begin
      errors++; $display("FAIL reject_accept: ready/busy/CSB got %b%b%b want 011", cmd_ready[0], busy[0], csb[0]);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL reject_idle: ready/busy got %b%b want 10", cmd_ready[0], busy[0]);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (edges !== 0 || csb[0] !== 1'b1) begin
      errors++; $display("FAIL reject_pins: edges %0d CSB %b want 0 1", edges, csb[0]);
    end
  endtask

  task automatic test_rw;
    clear_mon();
    resp = 16'hC300; wdata = 8'h5A; wdata_valid = 1'b1;
    issue(OP_RW, 8'h04, 4'd1);
`ifdef HKSPI_MASTER_RW_EN
    wait_idle("rw");
    wdata_valid = 1'b0;
    checks++;
    if (bits[23:0] !== 24'hC0045A || rises !== 24) begin
      errors++; $display("FAIL rw_sdi: bits %h rises %0d want c0045a 24", bits[23:0], rises);
    end
    checks++;
    if (rd_n !== 1 || rd_q[0] !== 8'hC3 || wr_n !== 1) begin
      errors++; $display("FAIL rw_data: rd %0d/%h wr %0d want 1/c3 1", rd_n, rd_q[0], wr_n);
    end
`else
    checks++;
    if (cmd_ready[0] !== 1'b0 || csb[0] !== 1'b1) begin
      errors++; $display("FAIL rw_reject: ready/CSB got %b%b want 01", cmd_ready[0], csb[0]);
    end
    repeat (20) @(negedge clk);
    wdata_valid = 1'b0;
    checks++;
    if (edges !== 0 || csb[0] !== 1'b1 || wr_n !== 0 || cmd_ready[0] !== 1'b1) begin
      errors++; $display("FAIL rw_pins: edges %0d CSB %b wr %0d ready %b want 0 1 0 1",
        edges, csb[0], wr_n, cmd_ready[0]);
    end
`endif
  endtask

  task automatic test_timing(input int g, input int div);
    int n = 0;
    int m = 0;
    cmd_op = OP_WRITE; cmd_addr = 8'h00; cmd_len = 4'd1; wdata = 8'hFF; wdata_valid = 1'b1;
    cmd_valid[g] = 1'b1;
    @(negedge clk);
    cmd_valid[g] = 1'b0;
    checks++;
    if (csb[g] !== 1'b0) begin errors++; $display("FAIL div%0d_csb: got %b want 0", div, csb[g]); end
    while (sck[g] === 1'b0 && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n !== div) begin errors++; $display("FAIL div%0d_lead: got %0d want %0d", div, n, div); end
    n = 0;
    while (sck[g] === 1'b1 && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n !== div) begin errors++; $display("FAIL div%0d_high: got %0d want %0d", div, n, div); end
    n = 0;
    while (csb[g] !== 1'b1 && n < 5000) begin
      if (sck[g] === 1'b1) m = 0; else m++;
      n++; @(negedge clk);
    end
    checks++;
    if (m !== div) begin errors++; $display("FAIL div%0d_tail: got %0d want %0d", div, m, div); end
    n = 0;
    while (cmd_ready[g] !== 1'b1 && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n !== 2 * div) begin errors++; $display("FAIL div%0d_guard: got %0d want %0d", div, n, 2 * div); end
    wdata_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n = 0;
    clear_mon();
    resp = 16'hFFFF;
    issue(OP_READ, 8'h20, 4'd4);
    while (edges < 10 && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (edges !== 10) begin errors++; $display("FAIL mid_edges: got %0d want 10", edges); end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (csb[0] !== 1'b1 || sck[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL mid_abort: CSB/SCK/busy got %b%b%b want 100", csb[0], sck[0], busy[0]);
    end
    repeat (20) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready[0] !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", cmd_ready[0]); end
    repeat (100) @(negedge clk);
    checks++;
    if (rd_n !== 0 || rises !== 5 || csb[0] !== 1'b1) begin
      errors++; $display("FAIL mid_quiet: rdata_valid %0d rises %0d CSB %b want 0 5 1", rd_n, rises, csb[0]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mon();
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_reject();
    test_rw();
    test_timing(1, 2);
    test_timing(2, 7);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
